// File: rtl/when_case_pkg.sv
// when_case_pkg: definitions shared by the select encoder and decoder.
//   - lane code constants (lane 1 combinational, lane 2 registered)
//   - decoder state encoding
//   - per-lane decode result struct
package when_case_pkg;

    localparam int CODE_W = 3;

    localparam logic [CODE_W-1:0] CODE1_HI = 3'h5;
    localparam logic [CODE_W-1:0] CODE1_LO = 3'h2;
    localparam logic [CODE_W-1:0] CODE2_HI = 3'h3;
    localparam logic [CODE_W-1:0] CODE2_LO = 3'h4;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    // Decode of one lane: legal code seen, and the select it carries.
    typedef struct packed {
        logic legal;
        logic sel;
    } chk_t;

endpackage

// File: rtl/when_case_code_check.sv
// when_case_code_check: combinational single-lane code decoder.
// Ports:
//   code - received lane code
//   hi   - code meaning select high on this lane
//   lo   - code meaning select low on this lane
//   chk  - {legal, sel}; sel is only meaningful when legal
module when_case_code_check
    import when_case_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    input  logic [CODE_W-1:0] hi,
    input  logic [CODE_W-1:0] lo,
    output chk_t              chk
);

    assign chk.legal = (code == hi) || (code == lo);
    assign chk.sel   = (code == hi);

endmodule

// File: rtl/when_case_decoder.sv
// when_case_decoder: receive side of the two-lane select-code link.
// Lane 2 lags lane 1 by a cycle, so the lane-1 decode is held for one
// stage and paired with the lane-2 code that arrives the next cycle.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   in_valid, code1 - lane-1 code for cycle t
//   code2           - lane-2 code; value at t+1 belongs to cycle t
//   clear           - clears fault state, err_cnt and consecutive count
//   out_valid       - strobe, sel1/sel2 hold a decoded pair
//   sel1, sel2      - recovered selects (held on illegal pairs)
//   err             - strobe, illegal pair detected
//   fault           - high while in FAULT
//   err_cnt         - saturating illegal-pair count
module when_case_decoder
    import when_case_pkg::*;
#(
    parameter int ERR_CNT_W = 8,
    parameter int ERR_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [CODE_W-1:0]    code1,
    input  logic [CODE_W-1:0]    code2,
    input  logic                 clear,
    output logic                 out_valid,
    output logic                 sel1,
    output logic                 sel2,
    output logic                 err,
    output logic                 fault,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    chk_t       d1, d2;
    chk_t       s1;
    logic       s1_valid;
    state_t     state;
    logic [3:0] consec;
    logic [3:0] consec_inc;
    logic       pair_ok;

    when_case_code_check u_chk1 (
        .code (code1),
        .hi   (CODE1_HI),
        .lo   (CODE1_LO),
        .chk  (d1)
    );

    when_case_code_check u_chk2 (
        .code (code2),
        .hi   (CODE2_HI),
        .lo   (CODE2_LO),
        .chk  (d2)
    );

    // Stage 1: hold the lane-1 decode until its lane-2 partner arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) s1 <= d1;
        end
    end

    assign pair_ok    = s1.legal && d2.legal;
    assign consec_inc = consec + 4'd1;
    assign fault      = (state == FAULT);

    // Stage 2: pair decode, lock/fault FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SYNC;
            consec    <= 4'd0;
            err_cnt   <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            sel1      <= 1'b0;
            sel2      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            if (s1_valid) begin
                if (pair_ok) begin
                    // FAULT swallows legal pairs until cleared.
                    if (state != FAULT) begin
                        out_valid <= 1'b1;
                        sel1      <= s1.sel;
                        sel2      <= d2.sel;
                        consec    <= 4'd0;
                        state     <= LOCKED;
                    end
                end else begin
                    err <= 1'b1;
                    if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
                    // Only a locked link can be pushed into FAULT.
                    if (state == LOCKED) begin
                        consec <= consec_inc;
                        if (consec_inc == 4'(ERR_LIMIT)) state <= FAULT;
                    end
                end
            end
            // clear overrides any state/counter update from this cycle's
            // pair, but the err strobe above still goes out.
            if (clear) begin
                state   <= SYNC;
                consec  <= 4'd0;
                err_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/when_case_decoder.md
# when_case_decoder

Receive-side decoder for the two-lane 3-bit select-code interface driven by the select encoder. Lane 1 carries a combinational code: 3'h5 means select high, 3'h2 means select low. Lane 2 carries a registered code: 3'h3 means high, 3'h4 means low, and it lags its source select by one cycle. The block re-aligns the two lanes, recovers the original sel1/sel2 pair, flags illegal codes, and declares a sticky fault after repeated corruption.

## Interface
Parameters:
- ERR_CNT_W, default 8: width of the saturating illegal-pair counter.
- ERR_LIMIT, default 4: number of consecutive illegal pairs that forces FAULT; legal range 1..15.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: reset, synchronous and active-high.
- in_valid, input, 1: marks the cycle t in which code1 is valid.
- code1, input, 3: lane-1 code for cycle t.
- code2, input, 3: lane-2 code; the value present at t+1 belongs to cycle t.
- clear, input, 1: synchronous clear of the fault state and err_cnt.
- out_valid, output, 1: one-cycle strobe; sel1/sel2 hold a decoded pair.
- sel1, output, 1: recovered lane-1 select.
- sel2, output, 1: recovered lane-2 select.
- err, output, 1: one-cycle strobe; an illegal pair was detected.
- fault, output, 1: high while the state is FAULT.
- err_cnt, output, ERR_CNT_W: saturating count of illegal pairs.

## Operation
- Stage 1 (edge ending cycle t, when in_valid=1):
  - capture the lane-1 decode: legal1 = (code1 is 3'h5 or 3'h2); bit1 = (code1 == 3'h5).
  - set s1_valid.
- Stage 2 (edge ending t+1, when s1_valid=1):
  - decode code2: legal2 = (code2 is 3'h3 or 3'h4); bit2 = (code2 == 3'h3).
  - pair is legal iff legal1 && legal2.
- code2 is ignored in any cycle where s1_valid=0.
- Back-to-back in_valid is supported: stage 1 accepts a new code every cycle.
- States:
  - SYNC: reset state.
    - Legal pair: go to LOCKED, out_valid=1.
    - Illegal pair: err=1, stay in SYNC; no FAULT from SYNC.
  - LOCKED:
    - Legal pair: out_valid=1, consecutive-error count = 0.
    - Illegal pair: err=1, out_valid=0, consecutive count +1.
    - If the incremented count equals ERR_LIMIT: go to FAULT.
  - FAULT:
    - out_valid is held at 0; err still pulses on illegal pairs.
    - Exit only via clear, which returns to SYNC.
- err_cnt:
  - +1 per illegal pair in any state; saturates at all-ones.
  - Cleared by clear or rst.
- On an illegal pair, sel1/sel2 hold their previous values.
- clear in the same cycle as an illegal pair: clear wins. Result is state SYNC, err_cnt=0, consecutive count=0; err still pulses.
- The consecutive-error counter is 4 bits wide.

## Timing
- Latency is 2 cycles: code1 at cycle t gives out_valid/sel1/sel2/err registered at t+2.
- Throughput is one pair per cycle.
- Reset values:
  - out_valid, sel1, sel2, err, fault = 0.
  - err_cnt = 0.
  - state = SYNC.
  - s1_valid = 0; consecutive count = 0.
- Reset mid-stream: a pair that is in flight is discarded; no out_valid or err follows the reset edge.
- fault rises in the same cycle as the err strobe of the ERR_LIMIT-th consecutive illegal pair.
- fault falls the cycle after clear is sampled.
- Back-to-back legal pairs from SYNC: the first pair produces out_valid and the transition to LOCKED together; no pair is lost.

## Structure
- Shared package when_case_pkg holds:
  - code constants CODE1_HI=3'h5, CODE1_LO=3'h2, CODE2_HI=3'h3, CODE2_LO=3'h4;
  - the 2-bit state encoding SYNC/LOCKED/FAULT.
- The encoder and this decoder both import the package.
- One sub-module, when_case_code_check: purely combinational. Inputs are a 3-bit code plus hi/lo constants; outputs are {legal, bit}. It is instantiated once per lane.

## Test plan
- Legal stream: after reset, drive (code1,code2@+1) = (5,3), (2,4), (5,4) on consecutive cycles.
  - Required: out_valid at t+2, t+3, t+4 with (sel1,sel2) = (1,1), (0,0), (1,0).
  - state LOCKED; err_cnt=0.
- Illegal in SYNC: pair (7,3).
  - Required: err=1, out_valid=0, state stays SYNC, err_cnt=1.
  - A following pair (2,3) gives out_valid with (0,1), state LOCKED.
- Fault entry, ERR_LIMIT=4: from LOCKED, drive 4 consecutive pairs (5,0).
  - Required: 4 err pulses, fault=1 with the 4th, err_cnt=4.
  - A following (5,3) gives no out_valid.
- Recovery: in FAULT, assert clear with an illegal pair.
  - Required: next cycle fault=0, state SYNC, err_cnt=0.
  - A pair (5,3) then gives out_valid (1,1).
- Saturation, ERR_CNT_W=2: drive 6 illegal pairs.
  - Required: err_cnt reaches 3 and stays at 3.
- Reset mid-flight: assert rst one cycle after in_valid with code1=5.
  - Required: no out_valid or err for that pair; all outputs 0.
